retire_trace_collector: RTL and testbench

RETIRE_TRACE_COLLECTOR -- requirements
Module: retire_trace_collector

---
 rtl/retire_trace_collector.sv | 195 +++++++++++++++++++
 tb/tb_retire_trace_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_collector.sv
// retire_trace_collector: buffers retired-instruction trace packets in a
// small FIFO and offers a three-state debug "peek" read of data memory.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   update_i              retire strobe; pc_i/instr_i/reg_addr_i/reg_data_i/
//                         mem_addr_i/mem_data_i/mem_wrt_i/mem_read_i form
//                         the packet captured on that edge
//   trace_valid_o/_ready_i/_pkt_o
//                         FIFO head handshake; packet is
//                         {pc, instr, reg_addr, reg_data, mem_addr,
//                          mem_data, mem_wrt, mem_read}, MSB first
//   level_o               FIFO occupancy
//   retire_cnt_o          wrapping count of retire strobes
//   drop_cnt_o            saturating count of packets lost to overflow
//   peek_req_i/_addr_i    start a debug read
//   peek_busy_o/_done_o/_data_o
//                         read status and captured data
//   addr_o, data_i        debug read port into the core (data_i is
//                         combinational from addr_o)
//
// Configuration
//   DROP_CNT_EN           when defined, builds the overflow counter;
//                         otherwise drop_cnt_o is tied to zero.

module retire_trace_collector #(
    parameter int XLEN  = 32,
    parameter int Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     update_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    input  logic [XLEN-1:0]          mem_addr_i,
    input  logic [XLEN-1:0]          mem_data_i,
    input  logic                     mem_wrt_i,
    input  logic                     mem_read_i,

    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [5*XLEN+6:0]        trace_pkt_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic [31:0]              retire_cnt_o,
    output logic [15:0]              drop_cnt_o,

    input  logic                     peek_req_i,
    input  logic [XLEN-1:0]          peek_addr_i,
    output logic                     peek_busy_o,
    output logic                     peek_done_o,
    output logic [XLEN-1:0]          peek_data_o,
    output logic [XLEN-1:0]          addr_o,
    input  logic [XLEN-1:0]          data_i
);

    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;
    localparam int PW = 5 * XLEN + 7;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(Depth);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;

    // ------------------------------------------------------------------
    // Trace FIFO
    // ------------------------------------------------------------------
    logic [PW-1:0] mem [Depth];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] level;
    logic [31:0]   retire_cnt;
    logic [PW-1:0] pkt_in;
    logic          full;
    logic          valid;
    logic          push;
    logic          pop;

    assign pkt_in = {pc_i, instr_i, reg_addr_i, reg_data_i,
                     mem_addr_i, mem_data_i, mem_wrt_i, mem_read_i};

    assign valid = (level != '0);
    assign full  = (level == LVL_MAX);
    assign pop   = valid & trace_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push  = update_i & (~full | pop);

    // Storage carries no reset; pointers and level define what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= pkt_in;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt <= '0;
        end else if (update_i) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign trace_valid_o = valid;
    assign trace_pkt_o   = mem[rptr];
    assign level_o       = level;
    assign retire_cnt_o  = retire_cnt;

`ifdef DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign drop = update_i & full & ~pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

    // ------------------------------------------------------------------
    // Peek FSM: latch address, give the core one cycle, capture data.
    // ------------------------------------------------------------------
    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] data_q;
    logic            done_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (peek_req_i) state_nxt = ADDR;
            ADDR:    state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == CAPT);
            if (state == IDLE && peek_req_i) begin
                addr_q <= peek_addr_i;
            end
            if (state == CAPT) begin
                data_q <= data_i;
            end
        end
    end

    assign peek_busy_o = (state != IDLE);
    assign peek_done_o = done_q;
    assign peek_data_o = data_q;
    assign addr_o      = addr_q;

endmodule

// File: tb/tb_retire_trace_collector.sv
// Self-checking bench for retire_trace_collector: table-driven FIFO
// vectors with a packet scoreboard, plus hand sequences for peek/reset.

module tb_retire_trace_collector;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int PW    = 5 * XLEN + 7;

    typedef logic [PW-1:0] pkt_t;

    typedef struct {
        bit          upd;
        bit          rdy;
        logic [31:0] pc;
        int          lvl;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            update_i;
    logic [31:0]     pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [4:0]      reg_addr_i;
    logic            mem_wrt_i, mem_read_i;
    logic            trace_valid_o;
    logic            trace_ready_i;
    logic [PW-1:0]   trace_pkt_o;
    logic [3:0]      level_o;
    logic [31:0]     retire_cnt_o;
    logic [15:0]     drop_cnt_o;
    logic            peek_req_i;
    logic [31:0]     peek_addr_i;
    logic            peek_busy_o, peek_done_o;
    logic [31:0]     peek_data_o, addr_o, data_i;

    retire_trace_collector #(.XLEN(XLEN), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .update_i(update_i),
        .pc_i(pc_i), .instr_i(instr_i), .reg_data_i(reg_data_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .reg_addr_i(reg_addr_i), .mem_wrt_i(mem_wrt_i),
        .mem_read_i(mem_read_i), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_pkt_o(trace_pkt_o),
        .level_o(level_o), .retire_cnt_o(retire_cnt_o),
        .drop_cnt_o(drop_cnt_o), .peek_req_i(peek_req_i),
        .peek_addr_i(peek_addr_i), .peek_busy_o(peek_busy_o),
        .peek_done_o(peek_done_o), .peek_data_o(peek_data_o),
        .addr_o(addr_o), .data_i(data_i)
    );

    always #5 clk = ~clk;

    // Core debug memory model.
    assign data_i = (addr_o == 32'h100) ? 32'hDEADBEEF : ~addr_o;

    pkt_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retire = 0;
    logic [15:0] exp_drop = 0;
    vec_t        vecs[22];

    function automatic pkt_t mk(input logic [31:0] pc);
        return {pc, pc ^ 32'h13, pc[6:2], ~pc, pc + 32'h4,
                pc ^ 32'h5A5A0000, pc[2], pc[3]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input pkt_t act, input pkt_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL head_pkt got %0h want %0h", act, exp);
        end
    endtask

    task automatic cycle(input bit upd, input logic [31:0] pc,
                         input bit rdy);
        pkt_t p;
        update_i      = upd;
        trace_ready_i = rdy;
        {pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i,
         mem_data_i, mem_wrt_i, mem_read_i} = mk(pc);
        #1;
        chk("valid", 64'(trace_valid_o), 64'(sb.size() != 0));
        if (rdy && sb.size() != 0) begin
            p = sb.pop_front();
            chk_pkt(trace_pkt_o, p);
        end
        if (upd) begin
            exp_retire = exp_retire + 32'd1;
            if (sb.size() < DEPTH) begin
                sb.push_back(mk(pc));
            end else begin
`ifdef DROP_CNT_EN
                if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        update_i      = 1'b0;
        trace_ready_i = 1'b0;
        chk("level", 64'(level_o), 64'(sb.size()));
        chk("retire_cnt", 64'(retire_cnt_o), 64'(exp_retire));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        exp_retire = 0;
        exp_drop   = 0;
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            vecs[i] = '{1'b1, 1'b0, 32'h1000 + 32'(i * 4), (i < 8) ? i + 1 : 8};
        vecs[10] = '{1'b1, 1'b1, 32'h2000, 8};
        for (int i = 0; i < 8; i++)
            vecs[11 + i] = '{1'b0, 1'b1, 32'h0, 7 - i};
        vecs[19] = '{1'b1, 1'b1, 32'h3000, 1};
        vecs[20] = '{1'b1, 1'b1, 32'h3004, 1};
        vecs[21] = '{1'b0, 1'b1, 32'h0, 0};

        update_i = 0; trace_ready_i = 0; peek_req_i = 0; peek_addr_i = 0;
        {pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i,
         mem_data_i, mem_wrt_i, mem_read_i} = '0;
        rst_i = 1'b0;
        @(negedge clk);
        do_reset();

        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_retire", 64'(retire_cnt_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_busy", 64'(peek_busy_o), 64'd0);
        chk("rst_done", 64'(peek_done_o), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);
        chk("rst_pdata", 64'(peek_data_o), 64'd0);

        // Single retire with consumer ready: no bypass, then pop.
        cycle(1'b1, 32'h80, 1'b1);
        chk("single_valid", 64'(trace_valid_o), 64'd1);
        chk("single_pc", 64'(trace_pkt_o[PW-1 -: 32]), 64'h80);
        cycle(1'b0, 32'h0, 1'b1);
        chk("single_empty", 64'(trace_valid_o), 64'd0);
        cycle(1'b0, 32'h0, 1'b1);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].upd, vecs[i].pc, vecs[i].rdy);
            chk("vec_level", 64'(level_o), 64'(vecs[i].lvl));
        end
        chk("fill_retire", 64'(retire_cnt_o), 64'd10);
`ifdef DROP_CNT_EN
        chk("fill_drop", 64'(drop_cnt_o), 64'd2);
`else
        chk("fill_drop", 64'(drop_cnt_o), 64'd0);
`endif
        chk("fill_head", 64'(trace_pkt_o[PW-1 -: 32]), 64'h1000);
        for (int i = 10; i < 22; i++) begin
            cycle(vecs[i].upd, vecs[i].pc, vecs[i].rdy);
            chk("vec_level", 64'(level_o), 64'(vecs[i].lvl));
        end

        // Peek concurrent with FIFO traffic; request in CAPT is lost.
        peek_addr_i = 32'h100;
        peek_req_i  = 1'b1;
        cycle(1'b1, 32'h4000, 1'b0);
        peek_req_i  = 1'b0;
        chk("peek_busy_a", 64'(peek_busy_o), 64'd1);
        chk("peek_addr", 64'(addr_o), 64'h100);
        chk("peek_done_a", 64'(peek_done_o), 64'd0);
        cycle(1'b1, 32'h4004, 1'b0);
        chk("peek_busy_c", 64'(peek_busy_o), 64'd1);
        chk("peek_done_c", 64'(peek_done_o), 64'd0);
        peek_addr_i = 32'h200;
        peek_req_i  = 1'b1;
        cycle(1'b0, 32'h0, 1'b1);
        peek_req_i  = 1'b0;
        chk("peek_done", 64'(peek_done_o), 64'd1);
        chk("peek_data", 64'(peek_data_o), 64'hDEADBEEF);
        chk("peek_idle", 64'(peek_busy_o), 64'd0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("peek_pulse", 64'(peek_done_o), 64'd0);
        chk("peek_lost", 64'(peek_busy_o), 64'd0);
        chk("peek_hold_a", 64'(addr_o), 64'h100);
        chk("peek_hold_d", 64'(peek_data_o), 64'hDEADBEEF);

        // Reset in ADDR with three packets buffered.
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h5000 + 32'(i * 4), 1'b0);
        peek_addr_i = 32'h300;
        peek_req_i  = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        peek_req_i  = 1'b0;
        chk("mid_busy", 64'(peek_busy_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_level", 64'(level_o), 64'd0);
        chk("mid_valid", 64'(trace_valid_o), 64'd0);
        chk("mid_busy0", 64'(peek_busy_o), 64'd0);
        chk("mid_addr", 64'(addr_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        exp_retire = 0;
        exp_drop   = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            chk("mid_nodone", 64'(peek_done_o), 64'd0);
        end

        // Retire counter wrap via preload.
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        exp_retire = 32'hFFFF_FFFF;
        chk("wrap_pre", 64'(retire_cnt_o), 64'hFFFF_FFFF);
        cycle(1'b1, 32'h6000, 1'b0);
        chk("wrap_zero", 64'(retire_cnt_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
